code_sched: RTL and testbench
=============================

CODE_SCHED -- requirements
Module: code_sched

Interface
REQ-001 SHALL have parameter bus_width, default 32, which sets the operand MSB index (operands are bus_width+1 bits).
REQ-002 SHALL have parameter NREQ, default 4, giving the requester count; only 4 is supported, and rsp_id is 2 bits.
REQ-003 SHALL have port sysclk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 4 bits: per-requester request valid.
REQ-006 SHALL have port req_sel, input, 12 bits: 3-bit selector per requester, requester i at [3i+2:3i].
REQ-007 SHALL have ports req_a and req_b, inputs, 4*(bus_width+1) bits each: operands per requester, packed like req_sel.
REQ-008 SHALL have port req_ready, output, 4 bits: per-requester accept, at most one bit high.
REQ-009 SHALL have port dp_sel, output, 3 bits: selector driven to the shared code datapath.
REQ-010 SHALL have ports dp_a and dp_b, outputs, bus_width+1 bits each: operands driven to the datapath.
REQ-011 SHALL have port dp_code, input, 8 bits: datapath result (code[9:2]), combinational from dp_*.
REQ-012 SHALL have ports rsp_valid (output, 1), rsp_id (output, 2), rsp_code (output, 8) and rsp_ready (input, 1): the response channel.
REQ-013 SHALL have port stat_count, output, 16 bits: count of completed transactions.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, RESP.
REQ-015 In IDLE with any req_valid high, SHALL assert req_ready combinationally for exactly one granted requester.
- Grant goes to the first requester with req_valid high, searching round-robin from last_grant+1 mod 4.
REQ-016 A transfer occurs on a sysclk edge where req_valid[i] && req_ready[i].
- On transfer: register dp_sel/dp_a/dp_b from requester i, store id i, set last_grant=i, go to ISSUE.
REQ-017 req_ready SHALL be 0 in ISSUE and RESP.
REQ-018 ISSUE SHALL last exactly one cycle; at its closing edge the block SHALL capture dp_code into rsp_code, set rsp_valid=1 and go to RESP.
REQ-019 In RESP, rsp_valid, rsp_id and rsp_code SHALL stay stable until rsp_ready=1 at an edge.
- At that edge: clear rsp_valid, increment stat_count, go to IDLE.
REQ-020 Latency SHALL be 2 cycles from the transfer edge to the first cycle with rsp_valid=1.
- Peak throughput is one transaction per 3 cycles with rsp_ready held high.
REQ-021 dp_sel, dp_a and dp_b SHALL hold their last issued values outside ISSUE.
REQ-022 A requester dropping req_valid before grant SHALL lose nothing; no request is latched without a transfer.
REQ-023 A requester re-requesting immediately after a grant SHALL lose priority to any other valid requester.
- All four requesters continuously valid: grant order is 0,1,2,3,0,...
REQ-024 stat_count SHALL saturate at 16'hFFFF.

Reset
REQ-025 reset SHALL be sampled only on the sysclk rising edge and SHALL override all other behaviour.
REQ-026 On reset: state=IDLE, last_grant=3 (requester 0 has first priority), rsp_valid=0, rsp_id=0, rsp_code=0, dp_sel=0, dp_a=0, dp_b=0, stat_count=0.
- req_ready=0 during the reset cycle.
REQ-027 Reset mid-transaction (ISSUE or RESP) SHALL discard the transaction: no response, no count increment, no re-acknowledge.

Configuration
REQ-028 Macro CODE_SCHED_STATS_EN defined: stat_count SHALL operate per REQ-019 and REQ-024.
REQ-029 Macro CODE_SCHED_STATS_EN undefined: stat_count SHALL be constant 0, with no counter register; all other behaviour is identical.

Verification
REQ-030 The bench SHALL model dp_code from the datapath truth table:
- sel 000/110 -> {3'b110, 5'b0}
- sel 101 -> 8'hE2
- sel 010 -> 8'hFF
- sel 011 -> 8'h00
- otherwise -> (a+b)[7:0]
REQ-031 Scenario: reset, then requester 2 sends sel=101 -> req_ready=0100, rsp_valid at +2 cycles, rsp_id=2, rsp_code=8'hE2.
REQ-032 Scenario: requester 0 sends sel=100, a=5, b=7 -> rsp_code=8'h0C; with rsp_ready low for 5 cycles, outputs are held stable.
REQ-033 Scenario: all four requesters valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 at 3-cycle spacing.
REQ-034 Scenario: reset asserted in the RESP state -> next cycle rsp_valid=0, stat_count=0, state IDLE, requester 0 has priority.
REQ-035 Scenario: with CODE_SCHED_STATS_EN defined, stat_count preloaded to 16'hFFFE, then 3 transactions -> stat_count=16'hFFFF; without the macro -> stat_count=0 throughout.

Source files
------------

// File: rtl/code_sched.sv
// code_sched: round-robin scheduler sharing one code datapath among four requesters.
// Optional macro CODE_SCHED_STATS_EN enables the completed-transaction counter.
//
// Ports:
//   sysclk      in   clock, rising edge
//   reset       in   synchronous active-high reset
//   req_valid   in   [3:0] per-requester request valid
//   req_sel     in   [11:0] 3-bit selector per requester, requester i at [3i+2:3i]
//   req_a/req_b in   [4*(bus_width+1)-1:0] operands per requester, packed like req_sel
//   req_ready   out  [3:0] one-hot accept, only in IDLE
//   dp_sel      out  [2:0] selector to the shared datapath
//   dp_a/dp_b   out  [bus_width:0] operands to the shared datapath
//   dp_code     in   [7:0] datapath result, combinational from dp_*
//   rsp_valid   out  response valid, held until rsp_ready
//   rsp_id      out  [1:0] requester that owns the response
//   rsp_code    out  [7:0] captured datapath result
//   rsp_ready   in   response accept
//   stat_count  out  [15:0] saturating count of completed transactions
//                         (constant 0 unless CODE_SCHED_STATS_EN is defined)

module code_sched #(
    parameter int bus_width = 32,
    parameter int NREQ      = 4
) (
    input  logic                       sysclk,
    input  logic                       reset,
    input  logic [3:0]                 req_valid,
    input  logic [11:0]                req_sel,
    input  logic [4*(bus_width+1)-1:0] req_a,
    input  logic [4*(bus_width+1)-1:0] req_b,
    output logic [3:0]                 req_ready,
    output logic [2:0]                 dp_sel,
    output logic [bus_width:0]         dp_a,
    output logic [bus_width:0]         dp_b,
    input  logic [7:0]                 dp_code,
    output logic                       rsp_valid,
    output logic [1:0]                 rsp_id,
    output logic [7:0]                 rsp_code,
    input  logic                       rsp_ready,
    output logic [15:0]                stat_count
);

    localparam int OPW = bus_width + 1;

    // After reset the last grant points at the highest requester,
    // so requester 0 is searched first.
    localparam logic [1:0] LAST_INIT = 2'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_grant;
    logic [1:0] grant_id;
    logic       grant_any;

    // Round-robin search starting one past the last grant; the fourth
    // step lands back on last_grant, so it is served only when alone.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = last_grant;
        for (int k = 1; k <= 4; k++) begin
            if (!grant_any && req_valid[last_grant + 2'(k)]) begin
                grant_any = 1'b1;
                grant_id  = last_grant + 2'(k);
            end
        end
    end

    always_comb begin
        req_ready = 4'b0000;
        if (!reset && state == IDLE && grant_any) begin
            req_ready = 4'b0001 << grant_id;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= LAST_INIT;
            rsp_valid  <= 1'b0;
            rsp_id     <= 2'd0;
            rsp_code   <= 8'd0;
            dp_sel     <= 3'd0;
            dp_a       <= '0;
            dp_b       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        dp_sel     <= req_sel[grant_id*3 +: 3];
                        dp_a       <= req_a[grant_id*OPW +: OPW];
                        dp_b       <= req_b[grant_id*OPW +: OPW];
                        rsp_id     <= grant_id;
                        last_grant <= grant_id;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_code  <= dp_code;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CODE_SCHED_STATS_EN
    logic [15:0] stat_q;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            stat_q <= 16'd0;
        end else if (state == RESP && rsp_ready && stat_q != 16'hFFFF) begin
            stat_q <= stat_q + 16'd1;
        end
    end

    assign stat_count = stat_q;
`else
    assign stat_count = 16'd0;
`endif

endmodule

// File: tb/tb_code_sched.sv
// tb_code_sched: directed self-checking bench for code_sched.
// Models the shared code datapath and checks grant, response and stats.

module tb_code_sched;

    localparam int W = 32;

`ifdef CODE_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic               sysclk = 1'b0;
    logic               reset;
    logic [3:0]         req_valid;
    logic [11:0]        req_sel;
    logic [4*(W+1)-1:0] req_a;
    logic [4*(W+1)-1:0] req_b;
    logic [3:0]         req_ready;
    logic [2:0]         dp_sel;
    logic [W:0]         dp_a;
    logic [W:0]         dp_b;
    logic [7:0]         dp_code;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [7:0]         rsp_code;
    logic               rsp_ready;
    logic [15:0]        stat_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    code_sched #(.bus_width(W), .NREQ(4)) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .dp_sel     (dp_sel),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_code    (dp_code),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_code   (rsp_code),
        .rsp_ready  (rsp_ready),
        .stat_count (stat_count)
    );

    always #5 sysclk = ~sysclk;

    // Shared datapath model
    always_comb begin
        case (dp_sel)
            3'b000, 3'b110: dp_code = {3'b110, 5'b0};
            3'b101:         dp_code = 8'hE2;
            3'b010:         dp_code = 8'hFF;
            3'b011:         dp_code = 8'h00;
            default:        dp_code = dp_a[7:0] + dp_b[7:0];
        endcase
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] s,
                           input logic [W:0] a, input logic [W:0] b);
        req_sel[3*i +: 3]     = s;
        req_a[i*(W+1) +: W+1] = a;
        req_b[i*(W+1) +: W+1] = b;
    endtask

    task automatic bump();
        if (exp_cnt < 65535) exp_cnt++;
    endtask

    function automatic logic [15:0] exp_stat();
        return STATS ? 16'(exp_cnt) : 16'h0000;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        tick();
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready got %b want 0000", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_code !== 8'd0) begin
            errors++;
            $display("FAIL reset_rsp got v=%b id=%0d code=%h want 0/0/00",
                     rsp_valid, rsp_id, rsp_code);
        end
        checks++;
        if (dp_sel !== 3'd0 || dp_a !== '0 || dp_b !== '0 || stat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_dp got sel=%h a=%h b=%h st=%h want zeros",
                     dp_sel, dp_a, dp_b, stat_count);
        end
        req_valid = 4'b0000;
        reset = 1'b0;
        exp_cnt = 0;
        tick();
    endtask

    task automatic test_single();
        set_req(2, 3'b101, 33'd0, 33'd0);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready got %b want 0100", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0 || dp_sel !== 3'b101) begin
            errors++;
            $display("FAIL single_issue got rdy=%b v=%b sel=%b want 0000/0/101",
                     req_ready, rsp_valid, dp_sel);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_code !== 8'hE2) begin
            errors++;
            $display("FAIL single_rsp got v=%b id=%0d code=%h want 1/2/e2",
                     rsp_valid, rsp_id, rsp_code);
        end
        rsp_ready = 1'b1;
        tick();
        bump();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || stat_count !== exp_stat()) begin
            errors++;
            $display("FAIL single_done got v=%b st=%h want 0/%h",
                     rsp_valid, stat_count, exp_stat());
        end
    endtask

    task automatic test_hold();
        set_req(0, 3'b100, 33'd5, 33'd7);
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL hold_ready got %b want 0001", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_code !== 8'h0C) begin
            errors++;
            $display("FAIL hold_rsp got v=%b id=%0d code=%h want 1/0/0c",
                     rsp_valid, rsp_id, rsp_code);
        end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_code !== 8'h0C ||
                dp_sel !== 3'b100 || dp_a !== 33'd5 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL hold_stable[%0d] got v=%b id=%0d code=%h sel=%b a=%h",
                         n, rsp_valid, rsp_id, rsp_code, dp_sel, dp_a);
            end
        end
        rsp_ready = 1'b1;
        tick();
        bump();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || dp_a !== 33'd5 || dp_b !== 33'd7 ||
            stat_count !== exp_stat()) begin
            errors++;
            $display("FAIL hold_done got v=%b a=%h b=%h st=%h want 0/5/7/%h",
                     rsp_valid, dp_a, dp_b, stat_count, exp_stat());
        end
    endtask

    task automatic test_drop();
        set_req(1, 3'b001, 33'd1, 33'd2);
        set_req(2, 3'b111, 33'd10, 33'd20);
        set_req(3, 3'b001, 33'd3, 33'd4);
        req_valid = 4'b0010;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL drop_ready1 got %b want 0010", req_ready);
        end
        tick();
        req_valid = 4'b0100;
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_code !== 8'h03) begin
            errors++;
            $display("FAIL drop_rsp1 got v=%b id=%0d code=%h want 1/1/03",
                     rsp_valid, rsp_id, rsp_code);
        end
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        tick();
        bump();
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL drop_ready3 got %b want 1000", req_ready);
        end
        tick();
        req_valid = 4'b0000;
        #1;
        checks++;
        if (dp_a !== 33'd3 || dp_b !== 33'd4) begin
            errors++;
            $display("FAIL drop_operands got a=%h b=%h want 3/4", dp_a, dp_b);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_code !== 8'h07) begin
            errors++;
            $display("FAIL drop_rsp3 got v=%b id=%0d code=%h want 1/3/07",
                     rsp_valid, rsp_id, rsp_code);
        end
        tick();
        bump();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] codes [4];
        codes[0] = 8'h02;
        codes[1] = 8'hC0;
        codes[2] = 8'hFF;
        codes[3] = 8'h00;
        set_req(0, 3'b100, 33'd1, 33'd1);
        set_req(1, 3'b000, 33'd9, 33'd9);
        set_req(2, 3'b010, 33'd4, 33'd4);
        set_req(3, 3'b011, 33'd6, 33'd6);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        #1;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = n % 4;
            checks++;
            if (req_ready !== (4'b0001 << g)) begin
                errors++;
                $display("FAIL b2b_grant[%0d] got %b want %b",
                         n, req_ready, 4'b0001 << g);
            end
            tick();
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL b2b_issue[%0d] got %b want 0000", n, req_ready);
            end
            tick();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_code !== codes[g]) begin
                errors++;
                $display("FAIL b2b_rsp[%0d] got v=%b id=%0d code=%h want 1/%0d/%h",
                         n, rsp_valid, rsp_id, rsp_code, g, codes[g]);
            end
            tick();
            bump();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        checks++;
        if (stat_count !== exp_stat()) begin
            errors++;
            $display("FAIL b2b_stat got %h want %h", stat_count, exp_stat());
        end
    endtask

    task automatic test_reset_resp();
        set_req(2, 3'b100, 33'd2, 33'd3);
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b0000;
        tick();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_inresp got v=%b want 1", rsp_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_code !== 8'd0 ||
            dp_sel !== 3'd0 || stat_count !== 16'd0) begin
            errors++;
            $display("FAIL rr_cleared got v=%b id=%0d code=%h sel=%b st=%h",
                     rsp_valid, rsp_id, rsp_code, dp_sel, stat_count);
        end
        rsp_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || stat_count !== 16'd0) begin
            errors++;
            $display("FAIL rr_noack got v=%b st=%h want 0/0000",
                     rsp_valid, stat_count);
        end
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rr_priority got %b want 0001", req_ready);
        end
        req_valid = 4'b0000;
        tick();
    endtask

    task automatic test_stats();
`ifdef CODE_SCHED_STATS_EN
        force dut.stat_q = 16'hFFFE;
        tick();
        release dut.stat_q;
        exp_cnt = 65534;
        #1;
`endif
        checks++;
        if (stat_count !== exp_stat()) begin
            errors++;
            $display("FAIL stat_preload got %h want %h", stat_count, exp_stat());
        end
        for (int n = 0; n < 3; n++) begin
            set_req(1, 3'b001, 33'(n), 33'd1);
            req_valid = 4'b0010;
            tick();
            req_valid = 4'b0000;
            tick();
            rsp_ready = 1'b1;
            tick();
            bump();
            rsp_ready = 1'b0;
            checks++;
            if (stat_count !== exp_stat()) begin
                errors++;
                $display("FAIL stat_txn[%0d] got %h want %h",
                         n, stat_count, exp_stat());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 4'b0000;
        req_sel = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_hold();
        test_drop();
        test_back_to_back();
        test_reset_resp();
        test_stats();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
